// File: rtl/llc_sweep_ctrl.sv
// LLC whole-cache sweep sequencer: post-reset invalidation sweep and flush (write-back + invalidate) sweep.
// Optional write-back statistics counter (wb_count) is enabled by defining LLC_SWEEP_STATS_EN.
module llc_sweep_ctrl #(
  parameter int SET_BITS = 9,
  parameter int WAYS     = 16,
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rst_state,
  input  logic                flush_req_valid,
  output logic                flush_req_ready,
  input  logic [WAYS-1:0]     way_valid,
  input  logic [WAYS-1:0]     way_dirty,
  output logic                rd_set_en,
  output logic                inv_set_en,
  output logic                inv_way_en,
  output logic [WAY_BITS-1:0] inv_way,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [SET_BITS-1:0] wb_set,
  output logic [WAY_BITS-1:0] wb_way,
  output logic [SET_BITS-1:0] sweep_set,
  output logic                rst_stall,
  output logic                flush_stall,
  output logic                flush_done
`ifdef LLC_SWEEP_STATS_EN
  ,
  output logic [15:0]         wb_count
`endif
);

  typedef enum logic [2:0] {
    RST_WR, IDLE, FL_RD, FL_SCAN, FL_WB, FL_INV, FL_DONE
  } state_t;

  localparam logic [SET_BITS-1:0] SET_MAX = '1;

  state_t              state_q, state_n;
  logic [WAYS-1:0]     pending_q, pending_n;
  logic [WAYS-1:0]     dirty_q, dirty_n;
  logic [WAY_BITS-1:0] cur_way_q, cur_way_n;

  logic [SET_BITS-1:0] sweep_set_n, wb_set_n;
  logic                rst_stall_n, flush_stall_n;
  logic                rd_set_en_n, inv_set_en_n, inv_way_en_n, wb_valid_n;
  logic [WAY_BITS-1:0] inv_way_n, wb_way_n;
  logic                flush_req_ready_n, flush_done_n;

  logic [WAYS-1:0]     pending_clr, sel_src, dirty_src;
  logic [WAY_BITS-1:0] sel_way;
  logic                sel_found, sel_dirty;
  logic                do_select, do_advance;

  assign pending_clr = pending_q & ~(WAYS'(1) << cur_way_q);
  // Scan picks from freshly read array data; INV picks from what remains pending.
  assign sel_src     = (state_q == FL_SCAN) ? way_valid : pending_clr;
  assign dirty_src   = (state_q == FL_SCAN) ? way_dirty : dirty_q;
  assign sel_dirty   = dirty_src[sel_way];

  always_comb begin
    sel_found = 1'b0;
    sel_way   = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (sel_src[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_way   = WAY_BITS'(i);
      end
    end
  end

  always_comb begin
    state_n           = state_q;
    sweep_set_n       = sweep_set;
    rst_stall_n       = rst_stall;
    flush_stall_n     = flush_stall;
    pending_n         = pending_q;
    dirty_n           = dirty_q;
    cur_way_n         = cur_way_q;
    rd_set_en_n       = 1'b0;
    inv_set_en_n      = 1'b0;
    inv_way_en_n      = 1'b0;
    inv_way_n         = inv_way;
    wb_valid_n        = 1'b0;
    wb_set_n          = wb_set;
    wb_way_n          = wb_way;
    flush_req_ready_n = 1'b0;
    flush_done_n      = 1'b0;
    do_select         = 1'b0;
    do_advance        = 1'b0;

    unique case (state_q)
      RST_WR: begin
        inv_set_en_n = 1'b1;
        // The set advances only after its invalidate strobe has actually been issued.
        if (inv_set_en) begin
          if (sweep_set == SET_MAX) begin
            sweep_set_n       = '0;
            rst_stall_n       = 1'b0;
            inv_set_en_n      = 1'b0;
            flush_req_ready_n = 1'b1;
            state_n           = IDLE;
          end else begin
            sweep_set_n = sweep_set + 1'b1;
          end
        end
      end
      IDLE: begin
        flush_req_ready_n = 1'b1;
        if (flush_req_valid && flush_req_ready) begin
          flush_stall_n     = 1'b1;
          sweep_set_n       = '0;
          rd_set_en_n       = 1'b1;
          flush_req_ready_n = 1'b0;
          state_n           = FL_RD;
        end
      end
      FL_RD: state_n = FL_SCAN;
      FL_SCAN: begin
        pending_n = way_valid;
        dirty_n   = way_dirty;
        if (way_valid == '0) do_advance = 1'b1;
        else                 do_select  = 1'b1;
      end
      FL_WB: begin
        wb_valid_n = 1'b1;
        if (wb_ready) begin
          wb_valid_n   = 1'b0;
          inv_way_en_n = 1'b1;
          inv_way_n    = cur_way_q;
          state_n      = FL_INV;
        end
      end
      FL_INV: begin
        pending_n = pending_clr;
        if (pending_clr != '0) do_select  = 1'b1;
        else                   do_advance = 1'b1;
      end
      FL_DONE: begin
        flush_stall_n     = 1'b0;
        flush_req_ready_n = 1'b1;
        state_n           = IDLE;
      end
      default: state_n = RST_WR;
    endcase

    if (do_select) begin
      cur_way_n = sel_way;
      if (sel_dirty) begin
        wb_valid_n = 1'b1;
        wb_set_n   = sweep_set;
        wb_way_n   = sel_way;
        state_n    = FL_WB;
      end else begin
        inv_way_en_n = 1'b1;
        inv_way_n    = sel_way;
        state_n      = FL_INV;
      end
    end

    if (do_advance) begin
      if (sweep_set == SET_MAX) begin
        sweep_set_n  = '0;
        flush_done_n = 1'b1;
        state_n      = FL_DONE;
      end else begin
        sweep_set_n = sweep_set + 1'b1;
        rd_set_en_n = 1'b1;
        state_n     = FL_RD;
      end
    end

    if (rst_state) begin
      state_n           = RST_WR;
      sweep_set_n       = '0;
      rst_stall_n       = 1'b1;
      flush_stall_n     = 1'b0;
      pending_n         = '0;
      rd_set_en_n       = 1'b0;
      inv_set_en_n      = 1'b1;
      inv_way_en_n      = 1'b0;
      wb_valid_n        = 1'b0;
      flush_req_ready_n = 1'b0;
      flush_done_n      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= RST_WR;
      sweep_set       <= '0;
      rst_stall       <= 1'b1;
      flush_stall     <= 1'b0;
      pending_q       <= '0;
      dirty_q         <= '0;
      cur_way_q       <= '0;
      rd_set_en       <= 1'b0;
      inv_set_en      <= 1'b0;
      inv_way_en      <= 1'b0;
      inv_way         <= '0;
      wb_valid        <= 1'b0;
      wb_set          <= '0;
      wb_way          <= '0;
      flush_req_ready <= 1'b0;
      flush_done      <= 1'b0;
    end else begin
      state_q         <= state_n;
      sweep_set       <= sweep_set_n;
      rst_stall       <= rst_stall_n;
      flush_stall     <= flush_stall_n;
      pending_q       <= pending_n;
      dirty_q         <= dirty_n;
      cur_way_q       <= cur_way_n;
      rd_set_en       <= rd_set_en_n;
      inv_set_en      <= inv_set_en_n;
      inv_way_en      <= inv_way_en_n;
      inv_way         <= inv_way_n;
      wb_valid        <= wb_valid_n;
      wb_set          <= wb_set_n;
      wb_way          <= wb_way_n;
      flush_req_ready <= flush_req_ready_n;
      flush_done      <= flush_done_n;
    end
  end

`ifdef LLC_SWEEP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_count <= '0;
    end else if (rst_state || (flush_req_valid && flush_req_ready)) begin
      wb_count <= '0;
    end else if (state_q == FL_WB && wb_ready && wb_count != '1) begin
      wb_count <= wb_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_llc_sweep_ctrl.sv
// Directed bench for llc_sweep_ctrl: reset sweep, flush sweeps, write-back backpressure, rst_state abort.
module tb_llc_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_state = 1'b0;
  logic        flush_req_valid = 1'b0;
  logic        flush_req_ready;
  logic [15:0] way_valid, way_dirty;
  logic        rd_set_en, inv_set_en, inv_way_en;
  logic [3:0]  inv_way, wb_way;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [8:0]  wb_set, sweep_set;
  logic        rst_stall, flush_stall, flush_done;
`ifdef LLC_SWEEP_STATS_EN
  logic [15:0] wb_count;
`endif

  llc_sweep_ctrl #(.SET_BITS(9), .WAYS(16)) dut (
    .clk(clk), .rst(rst), .rst_state(rst_state),
    .flush_req_valid(flush_req_valid), .flush_req_ready(flush_req_ready),
    .way_valid(way_valid), .way_dirty(way_dirty),
    .rd_set_en(rd_set_en), .inv_set_en(inv_set_en),
    .inv_way_en(inv_way_en), .inv_way(inv_way),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_set(wb_set), .wb_way(wb_way),
    .sweep_set(sweep_set), .rst_stall(rst_stall), .flush_stall(flush_stall),
    .flush_done(flush_done)
`ifdef LLC_SWEEP_STATS_EN
    , .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  // Array model: one target set holds the programmed valid/dirty pattern, all others are empty.
  bit          tgt_en = 1'b0;
  logic [8:0]  tgt_set = '0;
  logic [15:0] tgt_valid = '0, tgt_dirty = '0;
  assign way_valid = (tgt_en && sweep_set == tgt_set) ? tgt_valid : '0;
  assign way_dirty = (tgt_en && sweep_set == tgt_set) ? tgt_dirty : '0;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] ev_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one flush to completion, logging invalidate and write-back events as {type, way, set}.
  task automatic run_flush(input int hold, output int n_rd, output int n_hs, output int n_inv,
                           output bit stable, output bit stall_ok, output int rd_after,
                           output bit timeout);
    int wv_cnt;
    logic [8:0] s0;
    logic [3:0] w0;
    bit ev_flag;
    wv_cnt = 0; ev_flag = 0; s0 = '0; w0 = '0;
    n_rd = 0; n_hs = 0; n_inv = 0; stable = 1; stall_ok = 1; rd_after = -1; timeout = 1;
    ev_q.delete();
    flush_req_valid = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      tick();
      flush_req_valid = 1'b0;
      if (!flush_stall) stall_ok = 0;
      if (rd_set_en) begin
        n_rd++;
        if (ev_flag) begin rd_after = int'(sweep_set); ev_flag = 0; end
      end
      if (inv_way_en) begin
        n_inv++;
        ev_q.push_back({8'h01, 4'h0, inv_way, 7'h0, sweep_set});
        ev_flag = 1;
      end
      if (wb_valid) begin
        wv_cnt++;
        if (wv_cnt == 1) begin s0 = wb_set; w0 = wb_way; end
        else if (wb_set != s0 || wb_way != w0) stable = 0;
        if (wv_cnt > hold) begin
          wb_ready = 1'b1;
          n_hs++;
          ev_q.push_back({8'h02, 4'h0, wb_way, 7'h0, wb_set});
          ev_flag = 1;
          wv_cnt = 0;
        end else begin
          wb_ready = 1'b0;
        end
      end else begin
        wb_ready = 1'b1;  // must be ignored while wb_valid is low
      end
      if (flush_done) begin timeout = 0; break; end
    end
    wb_ready = 1'b0;
  endtask

  task automatic wait_reset_sweep(output int n_inv, output bit order_ok, output bit no_ready,
                                  output bit no_done, output bit timeout);
    int cnt;
    cnt = 0; order_ok = 1; no_ready = 1; no_done = 1; timeout = 1;
    for (int c = 0; c < 600; c++) begin
      if (!rst_stall) begin timeout = 0; break; end
      if (!inv_set_en || sweep_set != cnt[8:0]) order_ok = 0;
      if (flush_req_ready) no_ready = 0;
      if (flush_done) no_done = 0;
      cnt++;
      tick();
    end
    n_inv = cnt;
  endtask

  int  n_rd, n_hs, n_inv, rd_after;
  bit  stable, stall_ok, timeout, order_ok, no_ready, no_done;

  initial begin
    // Reset values, with a flush request already pending during the reset sweep.
    flush_req_valid = 1'b1;
    tick(); tick();
    check("rst_sweep_set", 32'(sweep_set), 32'd0);
    check("rst_rst_stall", 32'(rst_stall), 32'd1);
    check("rst_flush_stall", 32'(flush_stall), 32'd0);
    check("rst_strobes", {28'd0, rd_set_en, inv_set_en, inv_way_en, wb_valid}, 32'd0);
    check("rst_ready_done", {30'd0, flush_req_ready, flush_done}, 32'd0);
    check("rst_wb_fields", {19'd0, wb_set, wb_way}, 32'd0);
    check("rst_inv_way", 32'(inv_way), 32'd0);
    rst = 1'b1;
    tick();

    wait_reset_sweep(n_inv, order_ok, no_ready, no_done, timeout);
    check("rsweep_timeout", 32'(timeout), 32'd0);
    check("rsweep_cycles", 32'(n_inv), 32'd512);
    check("rsweep_order", 32'(order_ok), 32'd1);
    check("rsweep_ready_low", 32'(no_ready), 32'd1);
    check("idle_sweep_set", 32'(sweep_set), 32'd0);
    check("idle_ready", 32'(flush_req_ready), 32'd1);
    check("idle_inv_set_off", 32'(inv_set_en), 32'd0);

    // Flush of an empty cache, accepting the request held since reset.
    run_flush(0, n_rd, n_hs, n_inv, stable, stall_ok, rd_after, timeout);
    check("f0_timeout", 32'(timeout), 32'd0);
    check("f0_rd_pulses", 32'(n_rd), 32'd512);
    check("f0_wb", 32'(n_hs), 32'd0);
    check("f0_inv_way", 32'(n_inv), 32'd0);
    check("f0_stall_high", 32'(stall_ok), 32'd1);
    tick();
    check("f0_single_done", 32'(flush_done), 32'd0);
    check("f0_stall_low", 32'(flush_stall), 32'd0);
    check("f0_ready_back", 32'(flush_req_ready), 32'd1);

    // Set 3: way 0 clean, way 2 dirty; write-back held off for 10 cycles.
    tgt_en = 1; tgt_set = 9'd3; tgt_valid = 16'h0005; tgt_dirty = 16'h0004;
    run_flush(10, n_rd, n_hs, n_inv, stable, stall_ok, rd_after, timeout);
    check("f1_timeout", 32'(timeout), 32'd0);
    check("f1_events", 32'(ev_q.size()), 32'd3);
    if (ev_q.size() == 3) begin
      check("f1_ev0_inv_w0", ev_q[0], 32'h0100_0003);
      check("f1_ev1_wb_w2", ev_q[1], 32'h0202_0003);
      check("f1_ev2_inv_w2", ev_q[2], 32'h0102_0003);
    end
    check("f1_next_set", 32'(rd_after), 32'd4);
    check("f1_wb_stable", 32'(stable), 32'd1);
    check("f1_handshakes", 32'(n_hs), 32'd1);
    check("f1_rd_pulses", 32'(n_rd), 32'd512);
`ifdef LLC_SWEEP_STATS_EN
    check("f1_wb_count", 32'(wb_count), 32'd1);
`endif
    tick();

    // Last set with ways 0 and 15 both dirty.
    tgt_set = 9'd511; tgt_valid = 16'h8001; tgt_dirty = 16'h8001;
    run_flush(0, n_rd, n_hs, n_inv, stable, stall_ok, rd_after, timeout);
    check("f2_timeout", 32'(timeout), 32'd0);
    check("f2_events", 32'(ev_q.size()), 32'd4);
    if (ev_q.size() == 4) begin
      check("f2_ev0_wb_w0", ev_q[0], 32'h0200_01FF);
      check("f2_ev1_inv_w0", ev_q[1], 32'h0100_01FF);
      check("f2_ev2_wb_w15", ev_q[2], 32'h020F_01FF);
      check("f2_ev3_inv_w15", ev_q[3], 32'h010F_01FF);
    end
`ifdef LLC_SWEEP_STATS_EN
    check("f2_wb_count", 32'(wb_count), 32'd2);
`endif
    tick();

    // Abort a flush with a write-back outstanding at set 100.
    tgt_set = 9'd100; tgt_valid = 16'h0010; tgt_dirty = 16'h0010;
    wb_ready = 1'b0;
    flush_req_valid = 1'b1;
    timeout = 1;
    for (int c = 0; c < 2000; c++) begin
      tick();
      flush_req_valid = 1'b0;
      if (wb_valid) begin timeout = 0; break; end
    end
    check("ab_wb_reached", 32'(timeout), 32'd0);
    check("ab_wb_set", 32'(wb_set), 32'd100);
    check("ab_wb_way", 32'(wb_way), 32'd4);
    rst_state = 1'b1;
    tick();
    rst_state = 1'b0;
    check("ab_wb_valid_drop", 32'(wb_valid), 32'd0);
    check("ab_flush_stall", 32'(flush_stall), 32'd0);
    check("ab_rst_stall", 32'(rst_stall), 32'd1);
    check("ab_inv_set_restart", {23'd0, inv_set_en, sweep_set}, {23'd0, 1'b1, 9'd0});
    check("ab_no_done", 32'(flush_done), 32'd0);
`ifdef LLC_SWEEP_STATS_EN
    check("ab_wb_count_clr", 32'(wb_count), 32'd0);
`endif
    wait_reset_sweep(n_inv, order_ok, no_ready, no_done, timeout);
    check("ab_sweep_timeout", 32'(timeout), 32'd0);
    check("ab_sweep_cycles", 32'(n_inv), 32'd512);
    check("ab_sweep_order", 32'(order_ok), 32'd1);
    check("ab_sweep_no_done", 32'(no_done), 32'd1);
    check("ab_idle_ready", 32'(flush_req_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
